instr_prefetch_queue: RTL and testbench

- Small instruction FIFO between the fetch stage and the decode/execute stage of the MIPS datapath.
- Decouples the two stages with a valid/ready handshake, so a decode stall does not discard fetched words.
- Carries each instruction together with its PC.
- Flushes all contents on a branch-taken or jump redirect, so no wrong-path instruction reaches decode.

---
 rtl/pq_pkg.sv | 19 +
 rtl/pq_ptr_ctrl.sv | 80 ++++++++
 rtl/instr_prefetch_queue.sv | 83 ++++++++
 tb/tb_instr_prefetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pq_pkg;

    localparam int unsigned PQ_DW = 32;

    localparam logic [PQ_DW-1:0] PQ_NOP = 32'h0;

    typedef struct packed {
        logic [PQ_DW-1:0] instr;
        logic [PQ_DW-1:0] pc;
    } pq_entry_t;

    typedef enum logic [1:0] {
        PQ_EMPTY,
        PQ_PARTIAL,
        PQ_FULL
    } pq_state_t;

endpackage

// File: rtl/pq_ptr_ctrl.sv
// Pointer, occupancy and fill-state control for the prefetch queue.
// Optional same-cycle bypass when PQ_BYPASS_EN is defined.
module pq_ptr_ctrl
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          fetch_valid,
    input  logic          dec_ready,
    output logic          push_c,
    output logic          pop_c,
    output logic          full_c,
    output logic          empty_c,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;

    pq_state_t     state;
    pq_state_t     state_nxt;
    logic [AW-1:0] wr_nxt;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count_nxt;
    logic          bypass_take_c;

    assign full_c  = (state == PQ_FULL);
    assign empty_c = (state == PQ_EMPTY);

    // A bypassed word consumed in the same cycle never occupies an entry.
`ifdef PQ_BYPASS_EN
    assign bypass_take_c = empty_c & fetch_valid & dec_ready & ~flush;
`else
    assign bypass_take_c = 1'b0;
`endif

    assign push_c = fetch_valid & ~full_c & ~flush & ~bypass_take_c;
    assign pop_c  = ~empty_c & dec_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PQ_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
        end
    end

    // Next pointers/count; flush wins over push and pop.
    always_comb begin
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        count_nxt = count;
        state_nxt = state;
        if (flush) begin
            wr_nxt    = '0;
            rd_nxt    = '0;
            count_nxt = '0;
        end else begin
            if (push_c) wr_nxt = wr_ptr + AW'(1);
            if (pop_c)  rd_nxt = rd_ptr + AW'(1);
            if (push_c && !pop_c)      count_nxt = count + CW'(1);
            else if (pop_c && !push_c) count_nxt = count - CW'(1);
        end
        if (count_nxt == '0)              state_nxt = PQ_EMPTY;
        else if (count_nxt == CW'(DEPTH)) state_nxt = PQ_FULL;
        else                              state_nxt = PQ_PARTIAL;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction/PC FIFO between fetch and decode with redirect flush.
// Optional same-cycle empty bypass when PQ_BYPASS_EN is defined.
module instr_prefetch_queue
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned DW    = PQ_DW
) (
    input  logic          clk_pq,
    input  logic          rst_pq,
    input  logic          flush_pq,
    input  logic          fetch_valid,
    input  logic [DW-1:0] fetch_instr,
    input  logic [DW-1:0] fetch_pc,
    output logic          fetch_ready,
    output logic          dec_valid,
    output logic [DW-1:0] dec_instr,
    output logic [DW-1:0] dec_pc,
    input  logic          dec_ready,
    output logic [AW:0]   count_pq
);

    pq_entry_t     mem [DEPTH];
    pq_entry_t     head;
    logic          push_c;
    logic          pop_c;
    logic          full_c;
    logic          empty_c;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    pq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_ctrl (
        .clk         (clk_pq),
        .rst         (rst_pq),
        .flush       (flush_pq),
        .fetch_valid (fetch_valid),
        .dec_ready   (dec_ready),
        .push_c      (push_c),
        .pop_c       (pop_c),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count_pq)
    );

    assign fetch_ready = ~full_c;

    // Storage is not cleared on flush; the pointers alone define validity.
    always_ff @(posedge clk_pq) begin
        if (push_c) begin
            mem[wr_ptr] <= '{instr: PQ_DW'(fetch_instr), pc: PQ_DW'(fetch_pc)};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        dec_valid = ~empty_c;
        dec_instr = DW'(PQ_NOP);
        dec_pc    = DW'(PQ_NOP);
        if (!empty_c) begin
            dec_instr = DW'(head.instr);
            dec_pc    = DW'(head.pc);
        end
`ifdef PQ_BYPASS_EN
        if (empty_c && fetch_valid && !flush_pq) begin
            dec_valid = 1'b1;
            dec_instr = fetch_instr;
            dec_pc    = fetch_pc;
        end
`endif
    end

    // pop_c is consumed inside the controller; kept here for visibility.
    logic unused_c;
    assign unused_c = pop_c;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue; covers PQ_BYPASS_EN builds too.
module tb_instr_prefetch_queue;

    logic        clk_pq = 1'b0;
    logic        rst_pq = 1'b1;
    logic        flush_pq = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic [2:0]  count_pq;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   m_cnt = 0;
    int   tests = 0;
    int   errors = 0;

    instr_prefetch_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
        .clk_pq      (clk_pq),
        .rst_pq      (rst_pq),
        .flush_pq    (flush_pq),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .count_pq    (count_pq)
    );

    always #5 clk_pq = ~clk_pq;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] w(input logic [31:0] pc);
        return 32'h2400_0000 | pc;
    endfunction

    // Monitor: every accepted head is compared with the oldest expected word.
    always @(negedge clk_pq) begin
        if (rst_pq === 1'b0 && flush_pq === 1'b0 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL pop_unexpected got instr=%0h pc=%0h required none", dec_instr, dec_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_instr", 64'(dec_instr), 64'(e.instr));
                check("pop_pc", 64'(dec_pc), 64'(e.pc));
            end
        end
    end

    // One clock of stimulus; the bench's own occupancy model decides acceptance.
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic f, input logic rs);
        logic acc, pp, bp;
        fetch_valid = v;
        fetch_instr = i;
        fetch_pc    = p;
        dec_ready   = r;
        flush_pq    = f;
        rst_pq      = rs;
        acc = v && (m_cnt < 4) && !f && !rs;
        pp  = r && (m_cnt != 0) && !f && !rs;
        bp  = 1'b0;
`ifdef PQ_BYPASS_EN
        bp = v && r && (m_cnt == 0) && !f && !rs;
`endif
        if (acc) sb.push_back('{instr: i, pc: p});
        @(posedge clk_pq);
        if (f || rs) begin
            m_cnt = 0;
            sb.delete();
        end else if (!bp) begin
            m_cnt = m_cnt + int'(acc) - int'(pp);
        end
        #1;
    endtask

    initial begin
        @(posedge clk_pq);
        #1;
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_count", 64'(count_pq), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd1);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_instr", 64'(dec_instr), 64'h0);
        check("rst_dec_pc", 64'(dec_pc), 64'h0);

        // Three pushes with decode stalled
        cycle(1'b1, 32'h2008_0005, 32'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2009_0003, 32'h04, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0109_5020, 32'h08, 1'b0, 1'b0, 1'b0);
        check("t1_count", 64'(count_pq), 64'd3);
        check("t1_head_instr", 64'(dec_instr), 64'h2008_0005);
        check("t1_head_pc", 64'(dec_pc), 64'h00);

        // Fill, hold while full, pop one, then the held word goes in
        cycle(1'b1, 32'hAC0A_0000, 32'h0c, 1'b0, 1'b0, 1'b0);
        check("t2_full_count", 64'(count_pq), 64'd4);
        check("t2_full_ready", 64'(fetch_ready), 64'd0);
        cycle(1'b1, 32'h1234_5678, 32'h10, 1'b0, 1'b0, 1'b0);
        check("t2_hold_count", 64'(count_pq), 64'd4);
        check("t2_hold_ready", 64'(fetch_ready), 64'd0);
        cycle(1'b1, 32'h1234_5678, 32'h10, 1'b1, 1'b0, 1'b0);
        check("t2_pop_count", 64'(count_pq), 64'd3);
        check("t2_pop_ready", 64'(fetch_ready), 64'd1);
        cycle(1'b1, 32'h1234_5678, 32'h10, 1'b0, 1'b0, 1'b0);
        check("t2_accept_count", 64'(count_pq), 64'd4);
        check("t2_head_pc", 64'(dec_pc), 64'h04);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_drain_count", 64'(count_pq), 64'd0);
        check("t2_drain_valid", 64'(dec_valid), 64'd0);

        // Simultaneous push/pop stream; pointers wrap several times
        cycle(1'b1, w(32'h00), 32'h00, 1'b0, 1'b0, 1'b0);
        check("t3_prefill_count", 64'(count_pq), 64'd1);
        for (int k = 1; k < 10; k++) begin
            cycle(1'b1, w(32'(4 * k)), 32'(4 * k), 1'b1, 1'b0, 1'b0);
            check("t3_stream_count", 64'(count_pq), 64'd1);
        end
        check("t3_last_pc", 64'(dec_pc), 64'h24);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t3_drain_count", 64'(count_pq), 64'd0);

        // Flush with push and pop offered in the same cycle
        cycle(1'b1, w(32'h40), 32'h40, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, w(32'h44), 32'h44, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, w(32'h48), 32'h48, 1'b0, 1'b0, 1'b0);
        check("t4_pre_count", 64'(count_pq), 64'd3);
        cycle(1'b1, 32'hDEAD_BEEF, 32'h4c, 1'b1, 1'b1, 1'b0);
        check("t4_flush_count", 64'(count_pq), 64'd0);
        check("t4_flush_valid", 64'(dec_valid), 64'd0);
        check("t4_flush_instr", 64'(dec_instr), 64'h0);
        check("t4_flush_pc", 64'(dec_pc), 64'h0);
        check("t4_flush_ready", 64'(fetch_ready), 64'd1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t4_idle_count", 64'(count_pq), 64'd0);

        // Reset mid-operation, then a fresh push
        cycle(1'b1, w(32'h50), 32'h50, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, w(32'h54), 32'h54, 1'b0, 1'b0, 1'b0);
        check("t5_pre_count", 64'(count_pq), 64'd2);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("t5_rst_count", 64'(count_pq), 64'd0);
        check("t5_rst_ready", 64'(fetch_ready), 64'd1);
        check("t5_rst_valid", 64'(dec_valid), 64'd0);
        check("t5_rst_instr", 64'(dec_instr), 64'h0);
        check("t5_rst_pc", 64'(dec_pc), 64'h0);
        cycle(1'b1, w(32'h58), 32'h58, 1'b0, 1'b0, 1'b0);
        check("t5_push_count", 64'(count_pq), 64'd1);
        check("t5_push_instr", 64'(dec_instr), 64'(w(32'h58)));
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t5_pop_count", 64'(count_pq), 64'd0);

`ifdef PQ_BYPASS_EN
        // Same-cycle bypass on an empty queue
        fetch_valid = 1'b1;
        fetch_instr = 32'h0800_0004;
        fetch_pc    = 32'h80;
        dec_ready   = 1'b1;
        sb.push_back('{instr: 32'h0800_0004, pc: 32'h80});
        #2;
        check("t6_bypass_valid", 64'(dec_valid), 64'd1);
        check("t6_bypass_instr", 64'(dec_instr), 64'h0800_0004);
        @(posedge clk_pq);
        #1;
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        check("t6_bypass_count", 64'(count_pq), 64'd0);
`endif

        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("sb_leftover", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
